global_rf_multicontext: RTL and testbench
=========================================

// Module: global_rf_multicontext
// PURPOSE
//  Next-generation global register file for the CGRA: parametrised in/out port count, depth, width and
//  number of configuration contexts. The on-chip serial config chain holds one config word per context.
//  A context counter steps through the words cycle by cycle, so modulo-scheduled loops can change
//  write-enables and addresses every cycle. Sits at array level beside the I/O ports.
// PARAMETERS
//  NUM_IN    4   write ports
//  NUM_OUT   8   read ports
//  DEPTH     8   registers (>=2); ADDR_W = clog2(DEPTH)
//  WIDTH     32  data width
//  CONTEXTS  4   config contexts (>=1); CTX_W = max(1, clog2(CONTEXTS))
//  derived: CFG_W = NUM_IN*(1+ADDR_W) + NUM_OUT*ADDR_W; CHAIN_W = CONTEXTS*CFG_W
// PORTS
//  CGRA_Clock    in   1              sole clock
//  CGRA_Reset    in   1              synchronous, active-high reset
//  ConfigIn      in   1              serial config data
//  ConfigEnable  in   1              shift the chain by one bit this cycle
//  ConfigOut     out  1              chain tail (cfg[0]), feeds the next block
//  run           in   1              advance the context counter
//  in_flat       in   NUM_IN*WIDTH   write data; port i = [i*WIDTH +: WIDTH]
//  out_flat      out  NUM_OUT*WIDTH  registered read data; port j = [j*WIDTH +: WIDTH]
//  context       out  CTX_W          current context index
// BEHAVIOUR
//  Single clock: CGRA_Clock. CGRA_Reset is synchronous and active-high. All state updates on the
//  CGRA_Clock rising edge.
//  Reset (highest priority): storage, cfg chain, out_flat and context all go to 0 (ConfigOut=0).
//  Chain: when ConfigEnable=1, cfg <= {ConfigIn, cfg[CHAIN_W-1:1]}. ConfigOut = cfg[0].
//    The first bit shifted in ends at cfg[0] after CHAIN_W shifts.
//  Context k word W = cfg[k*CFG_W +: CFG_W], LSB first:
//    WE[i]       = W[i]
//    addr_in[i]  = W[NUM_IN + i*ADDR_W +: ADDR_W]
//    addr_out[j] = W[NUM_IN*(1+ADDR_W) + j*ADDR_W +: ADDR_W]
//  Config mode (ConfigEnable=1): no register writes; context and out_flat hold.
//  Run mode (ConfigEnable=0), with current context c:
//    - write: for each i with WE[i], reg[addr_in[i]] <= in_i.
//    - write conflict (same address): highest-index port wins.
//    - read: out_j <= reg[addr_out[j]], taken from the pre-edge value. 1-cycle latency;
//      read-during-write returns OLD data; written data is visible on the next cycle's read.
//    - context <= run ? (c==CONTEXTS-1 ? 0 : c+1) : c. Wraps at CONTEXTS-1.
//      CONTEXTS=1 keeps context at 0.
//  Out-of-range address (>= DEPTH, non-power-of-2 depth): write ignored, read returns 0.
//  ConfigEnable rising mid-run: freezes state at once. Dropping it resumes from the held context.
//    The counter is not reset by reconfiguration; assert CGRA_Reset to restart at context 0.
//    CGRA_Reset also clears config.
//  No combinational path from inputs to out_flat/context. ConfigOut depends only on cfg[0].
// TESTING (defaults: ADDR_W=3, CFG_W=40, CHAIN_W=160)
//  1 Reset: assert CGRA_Reset 1 cycle mid-run -> next cycle out_flat=0, context=0, ConfigOut=0;
//    reads of all regs give 0.
//  2 Chain: shift a 160-bit pattern then 160 more zeros -> ConfigOut replays the pattern exactly,
//    delayed 160 cycles; context/out_flat frozen throughout.
//  3 Write/read latency: ctx0 WE0=1 addr_in0=5 in0=32'hDEADBEEF, addr_out3=5 -> out3 shows old value
//    1 cycle later, then 32'hDEADBEEF from the read issued the following cycle.
//  4 Conflict: WE1=WE3=1, both addr 2, in1=1, in3=3 -> reg2=3.
//  5 Contexts: CONTEXTS=4, run=1, ctx k writes k+10 to reg k, reads reg (k-1)%4 -> context
//    0,1,2,3,0; after one lap out0 sequence 13,10,11,12. run=0 holds context.
//  6 DEPTH=6: write addr 7 -> no reg changes; read addr 6 -> 0.

Source files
------------

// File: rtl/global_rf_multicontext_if.sv
// Array-level bus of the multi-context global register file:
// serial config chain, run strobe, write data and registered read data.
interface global_rf_multicontext_if #(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 8,
  parameter int WIDTH   = 32,
  parameter int CTX_W   = 2
);
  logic                     ConfigIn;
  logic                     ConfigEnable;
  logic                     ConfigOut;
  logic                     run;
  logic [NUM_IN*WIDTH-1:0]  in_flat;
  logic [NUM_OUT*WIDTH-1:0] out_flat;
  // "context" is a reserved word, so the index travels as ctx
  logic [CTX_W-1:0]         ctx;

  modport master (
    output ConfigIn,
    output ConfigEnable,
    output run,
    output in_flat,
    input  ConfigOut,
    input  out_flat,
    input  ctx
  );

  modport slave (
    input  ConfigIn,
    input  ConfigEnable,
    input  run,
    input  in_flat,
    output ConfigOut,
    output out_flat,
    output ctx
  );
endinterface

// File: rtl/global_rf_multicontext.sv
// Multi-context global register file: one serially loaded config word
// per context, stepped cycle by cycle by a wrapping context counter.
module global_rf_multicontext #(
  parameter int NUM_IN   = 4,
  parameter int NUM_OUT  = 8,
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 32,
  parameter int CONTEXTS = 4
) (
  input  logic CGRA_Clock,
  input  logic CGRA_Reset,
  global_rf_multicontext_if.slave bus
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int CTX_W   = (CONTEXTS > 1) ? $clog2(CONTEXTS) : 1;
  localparam int AI_OFF  = NUM_IN;
  localparam int AO_OFF  = NUM_IN * (1 + ADDR_W);
  localparam int CFG_W   = AO_OFF + NUM_OUT * ADDR_W;
  localparam int CHAIN_W = CONTEXTS * CFG_W;

  logic [CHAIN_W-1:0]       cfg_q;
  logic [CHAIN_W-1:0]       cfg_d;
  logic [WIDTH-1:0]         mem_q [DEPTH];
  logic [WIDTH-1:0]         mem_d [DEPTH];
  logic [NUM_OUT*WIDTH-1:0] out_q;
  logic [NUM_OUT*WIDTH-1:0] out_d;
  logic [CTX_W-1:0]         ctx_q;
  logic [CTX_W-1:0]         ctx_d;

  logic [CFG_W-1:0]  word;
  logic [NUM_IN-1:0] we;
  logic [ADDR_W-1:0] a_in  [NUM_IN];
  logic [ADDR_W-1:0] a_out [NUM_OUT];

  always_comb begin
    word = '0;
    for (int k = 0; k < CONTEXTS; k++) begin
      if (ctx_q == CTX_W'(k)) begin
        word = cfg_q[k*CFG_W +: CFG_W];
      end
    end
  end

  always_comb begin
    we = word[NUM_IN-1:0];
    for (int i = 0; i < NUM_IN; i++) begin
      a_in[i] = word[AI_OFF + i*ADDR_W +: ADDR_W];
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      a_out[j] = word[AO_OFF + j*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    cfg_d = cfg_q;
    if (bus.ConfigEnable) begin
      cfg_d = {bus.ConfigIn, cfg_q[CHAIN_W-1:1]};
    end
  end

  // ascending port order lets the highest-index writer win;
  // addresses past DEPTH match no register and are dropped
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      mem_d[r] = mem_q[r];
    end
    if (!bus.ConfigEnable) begin
      for (int i = 0; i < NUM_IN; i++) begin
        for (int r = 0; r < DEPTH; r++) begin
          if (we[i] && a_in[i] == ADDR_W'(r)) begin
            mem_d[r] = bus.in_flat[i*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  always_comb begin
    out_d = out_q;
    if (!bus.ConfigEnable) begin
      for (int j = 0; j < NUM_OUT; j++) begin
        out_d[j*WIDTH +: WIDTH] = '0;
        for (int r = 0; r < DEPTH; r++) begin
          if (a_out[j] == ADDR_W'(r)) begin
            out_d[j*WIDTH +: WIDTH] = mem_q[r];
          end
        end
      end
    end
  end

  always_comb begin
    ctx_d = ctx_q;
    if (!bus.ConfigEnable && bus.run) begin
      if (ctx_q == CTX_W'(CONTEXTS - 1)) begin
        ctx_d = '0;
      end else begin
        ctx_d = ctx_q + CTX_W'(1);
      end
    end
  end

  always_ff @(posedge CGRA_Clock) begin
    if (CGRA_Reset) begin
      cfg_q <= '0;
      out_q <= '0;
      ctx_q <= '0;
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      cfg_q <= cfg_d;
      out_q <= out_d;
      ctx_q <= ctx_d;
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= mem_d[r];
      end
    end
  end

  assign bus.ConfigOut = cfg_q[0];
  assign bus.out_flat  = out_q;
  assign bus.ctx       = ctx_q;

endmodule

// File: tb/tb_global_rf_multicontext.sv
// Bench for the multi-context register file: DEPTH=8 and DEPTH=6 copies
// share one stimulus and are checked against a behavioural model.
module tb_global_rf_multicontext;

  localparam int NI  = 4;
  localparam int NO  = 8;
  localparam int W   = 32;
  localparam int CX  = 4;
  localparam int CW  = 2;
  localparam int CFG = 40;
  localparam int CH  = 160;
  localparam int OW  = NO * W;

  logic clk = 1'b0;
  logic rst;
  logic cen;
  logic cin;
  logic run;
  logic [W-1:0] din [NI];

  always #5 clk = ~clk;

  global_rf_multicontext_if #(
    .NUM_IN(NI), .NUM_OUT(NO), .WIDTH(W), .CTX_W(CW)
  ) b8 ();
  global_rf_multicontext_if #(
    .NUM_IN(NI), .NUM_OUT(NO), .WIDTH(W), .CTX_W(CW)
  ) b6 ();

  assign b8.ConfigIn     = cin;
  assign b8.ConfigEnable = cen;
  assign b8.run          = run;
  assign b8.in_flat      = {din[3], din[2], din[1], din[0]};
  assign b6.ConfigIn     = cin;
  assign b6.ConfigEnable = cen;
  assign b6.run          = run;
  assign b6.in_flat      = {din[3], din[2], din[1], din[0]};

  global_rf_multicontext #(
    .NUM_IN(NI), .NUM_OUT(NO), .DEPTH(8), .WIDTH(W), .CONTEXTS(CX)
  ) u8 (
    .CGRA_Clock(clk),
    .CGRA_Reset(rst),
    .bus(b8)
  );

  global_rf_multicontext #(
    .NUM_IN(NI), .NUM_OUT(NO), .DEPTH(6), .WIDTH(W), .CONTEXTS(CX)
  ) u6 (
    .CGRA_Clock(clk),
    .CGRA_Reset(rst),
    .bus(b6)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [OW-1:0] got,
                     input logic [OW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // behavioural model: chain bits, register arrays, expected outputs
  logic [CH-1:0] m_cfg;
  int            m_ctx;
  logic [W-1:0]  m_mem [2][8];
  logic [W-1:0]  m_out [2][NO];
  bit            started = 0;

  function automatic int dep(int d);
    return (d == 0) ? 8 : 6;
  endfunction

  function automatic int fld(int k, int off, int w);
    int v = 0;
    for (int b = 0; b < w; b++) begin
      if (m_cfg[k*CFG + off + b]) v += (1 << b);
    end
    return v;
  endfunction

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      m_cfg = '0;
      m_ctx = 0;
      for (int d = 0; d < 2; d++) begin
        for (int r = 0; r < 8; r++) m_mem[d][r] = '0;
        for (int j = 0; j < NO; j++) m_out[d][j] = '0;
      end
    end else if (cen) begin
      m_cfg = {cin, m_cfg[CH-1:1]};
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int j = 0; j < NO; j++) begin
          int a;
          a = fld(m_ctx, 16 + 3*j, 3);
          m_out[d][j] = (a < dep(d)) ? m_mem[d][a] : '0;
        end
        for (int i = 0; i < NI; i++) begin
          if (fld(m_ctx, i, 1) == 1) begin
            int a;
            a = fld(m_ctx, 4 + 3*i, 3);
            if (a < dep(d)) m_mem[d][a] = din[i];
          end
        end
      end
      if (run) m_ctx = (m_ctx + 1) % CX;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        logic [OW-1:0] e;
        for (int j = 0; j < NO; j++) e[j*W +: W] = m_out[d][j];
        if (d == 0) begin
          chk("m_out8", b8.out_flat, e);
          chk("m_ctx8", OW'(b8.ctx), OW'(m_ctx));
          chk("m_cfgout8", OW'(b8.ConfigOut), OW'(m_cfg[0]));
        end else begin
          chk("m_out6", b6.out_flat, e);
          chk("m_ctx6", OW'(b6.ctx), OW'(m_ctx));
          chk("m_cfgout6", OW'(b6.ConfigOut), OW'(m_cfg[0]));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [CH-1:0] v);
    cen = 1'b1;
    for (int b = 0; b < CH; b++) begin
      cin = v[b];
      cyc();
    end
    cen = 1'b0;
    cin = 1'b0;
  endtask

  // word layout: {addr_out[7..0], addr_in[3..0], we[3..0]}
  function automatic logic [CFG-1:0] mkw(input logic [3:0] we,
                                         input logic [11:0] ai,
                                         input logic [23:0] ao);
    return {ao, ai, we};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH-1:0]  pat;
    logic [CH-1:0]  rep;
    logic [CH-1:0]  v;
    logic [23:0]    ao;
    int             seq [4];

    rst = 1'b1;
    cen = 1'b0;
    cin = 1'b0;
    run = 1'b0;
    for (int i = 0; i < NI; i++) din[i] = '0;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_ctx", OW'(b8.ctx), '0);
    chk("rst_out", b8.out_flat, '0);
    chk("rst_cfgout", OW'(b8.ConfigOut), '0);

    // chain replay, with run high to show the freeze
    pat = {32'h0F1E2D3C, 32'hA5A5F00F, 32'h12345678,
           32'hCAFEBABE, 32'h80000001};
    run = 1'b1;
    load(pat);
    cen = 1'b1;
    for (int m = 0; m < CH; m++) begin
      rep[m] = b8.ConfigOut;
      cin = 1'b0;
      cyc();
    end
    cen = 1'b0;
    run = 1'b0;
    chk("chain_replay", OW'(rep), OW'(pat));
    chk("chain_ctx_frozen", OW'(b8.ctx), '0);

    // write/read latency on reg5 via out3
    v = '0;
    v[CFG-1:0] = mkw(4'b0001, 12'd5, 24'd5 << 9);
    load(v);
    din[0] = 32'h11111111;
    cyc();
    chk("lat_old0", OW'(b8.out_flat[3*W +: W]), OW'(32'h0));
    din[0] = 32'hDEADBEEF;
    cyc();
    chk("lat_old1", OW'(b8.out_flat[3*W +: W]), OW'(32'h11111111));
    cyc();
    chk("lat_new", OW'(b8.out_flat[3*W +: W]), OW'(32'hDEADBEEF));

    // write conflict: ports 1 and 3 both hit reg2
    v = '0;
    v[CFG-1:0] = mkw(4'b1010, (12'd2 << 3) | (12'd2 << 9), 24'd2);
    load(v);
    din[0] = 32'd7;
    din[1] = 32'd1;
    din[2] = 32'd9;
    din[3] = 32'd3;
    cyc();
    cyc();
    chk("conflict", OW'(b8.out_flat[0 +: W]), OW'(32'd3));

    // contexts: ctx k writes k+10 to reg k, reads reg (k+3)%4
    v = '0;
    for (int k = 0; k < CX; k++) begin
      v[k*CFG +: CFG] = mkw(4'b0001, 12'(k), 24'((k + 3) % 4));
    end
    load(v);
    seq = '{13, 10, 11, 12};
    run = 1'b1;
    for (int t = 0; t < 9; t++) begin
      if (t <= 4) chk("ctx_seq", OW'(b8.ctx), OW'(t % 4));
      din[0] = W'((t % 4) + 10);
      cyc();
      if (t >= 4 && t <= 7) begin
        chk("lap_out0", OW'(b8.out_flat[0 +: W]), OW'(seq[t-4]));
      end
    end
    run = 1'b0;
    cyc();
    cyc();
    chk("ctx_hold", OW'(b8.ctx), OW'(1));

    // config mid-run freezes context, resumes on release
    run = 1'b1;
    cen = 1'b1;
    cin = 1'b1;
    for (int s = 0; s < 16; s++) cyc();
    chk("freeze_ctx", OW'(b8.ctx), OW'(1));
    chk("freeze_cfgout", OW'(b8.ConfigOut), OW'(1));
    cen = 1'b0;
    cin = 1'b0;
    cyc();
    chk("resume_ctx", OW'(b8.ctx), OW'(2));

    // reset mid-run
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    run = 1'b0;
    chk("mid_rst_ctx", OW'(b8.ctx), '0);
    chk("mid_rst_out", b8.out_flat, '0);
    chk("mid_rst_cfgout", OW'(b8.ConfigOut), '0);
    for (int j = 0; j < NO; j++) ao[3*j +: 3] = 3'(j);
    v = '0;
    v[CFG-1:0] = mkw(4'b0000, 12'd0, ao);
    load(v);
    cyc();
    chk("rst_read_all8", b8.out_flat, '0);
    chk("rst_read_all6", b6.out_flat, '0);

    // out-of-range: write 7, read 6 and 7 on the DEPTH=6 copy
    for (int j = 0; j < NO; j++) ao[3*j +: 3] = 3'((j + 6) % 8);
    v = '0;
    v[CFG-1:0] = mkw(4'b0001, 12'd7, ao);
    load(v);
    for (int i = 0; i < NI; i++) din[i] = '0;
    din[0] = 32'h00000BAD;
    cyc();
    din[0] = 32'h0;
    cyc();
    chk("oor_d8_reg7", OW'(b8.out_flat[1*W +: W]), OW'(32'hBAD));
    chk("oor_d8_reg6", OW'(b8.out_flat[0 +: W]), OW'(32'h0));
    chk("oor_d6_all", b6.out_flat, '0);

    cyc();
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
